// File: rtl/instr_fetch_if.sv
// Bus bundle for the instruction prefetch unit: ROM address/data, redirect
// request and the decoder-facing byte window.
interface instr_fetch_if #(
    parameter int WIDTH      = 8,
    parameter int OUTMUL     = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 4
);
    logic [ADDR_WIDTH-1:0]           rom_addr;
    logic [WIDTH*OUTMUL-1:0]         rom_data;
    logic                            jmp;
    logic [ADDR_WIDTH-1:0]           jmp_addr;
    logic [$clog2(OUTMUL+1)-1:0]     out_take;
    logic [WIDTH*OUTMUL-1:0]         out_bytes;
    logic [$clog2(DEPTH+1)-1:0]      out_count;
    logic [ADDR_WIDTH-1:0]           out_pc;

    modport master (
        output rom_addr, out_bytes, out_count, out_pc,
        input  rom_data, jmp, jmp_addr, out_take
    );

    modport slave (
        input  rom_addr, out_bytes, out_count, out_pc,
        output rom_data, jmp, jmp_addr, out_take
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction prefetch: fetches OUTMUL bytes per cycle from a combinational ROM
// into a circular byte queue and presents the oldest bytes with their PC.
module instr_fetch #(
    parameter int                    WIDTH      = 8,
    parameter int                    OUTMUL     = 2,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);
    localparam int unsigned OM    = OUTMUL;
    localparam int unsigned DP    = DEPTH;
    localparam int          PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]      q [DEPTH];
    logic [ADDR_WIDTH-1:0] fa;
    logic [ADDR_WIDTH-1:0] pc;
    logic [PTR_W-1:0]      head;
    logic [CNT_W-1:0]      count;
    logic                  push;
    logic [CNT_W-1:0]      pop;

    function automatic logic [PTR_W-1:0] wrap(input int unsigned v);
        return PTR_W'(v % DP);
    endfunction

    always_comb begin
        push = (32'(count) + OM <= DP);
        pop  = (CNT_W'(bus.out_take) <= count) ? CNT_W'(bus.out_take) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fa    <= RESET_ADDR;
            pc    <= RESET_ADDR;
            head  <= '0;
            count <= '0;
        end else if (bus.jmp) begin
            fa    <= bus.jmp_addr;
            pc    <= bus.jmp_addr;
            head  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                // Tail is head+count, taken from start-of-cycle state so a
                // same-cycle pop cannot shift where new bytes land.
                for (int unsigned i = 0; i < OM; i++)
                    q[wrap(32'(head) + 32'(count) + i)] <= bus.rom_data[WIDTH*i +: WIDTH];
                fa <= fa + ADDR_WIDTH'(OM);
            end
            head  <= wrap(32'(head) + 32'(pop));
            pc    <= pc + ADDR_WIDTH'(pop);
            count <= count + (push ? CNT_W'(OM) : '0) - pop;
        end
    end

    always_comb begin
        bus.rom_addr  = fa;
        bus.out_pc    = pc;
        bus.out_count = count;
        bus.out_bytes = '0;
        for (int unsigned i = 0; i < OM; i++)
            if (i < 32'(count))
                bus.out_bytes[WIDTH*i +: WIDTH] = q[wrap(32'(head) + i)];
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a 256-byte ROM where rom[a] = a.
module tb_instr_fetch;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    instr_fetch_if #(.WIDTH(8), .OUTMUL(2), .ADDR_WIDTH(16), .DEPTH(4)) bus ();

    instr_fetch #(
        .WIDTH(8), .OUTMUL(2), .ADDR_WIDTH(16), .DEPTH(4), .RESET_ADDR(16'h0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always_comb begin
        logic [16:0] a;
        bus.rom_data = '0;
        for (int i = 0; i < 2; i++) begin
            a = {1'b0, bus.rom_addr} + 17'(i);
            bus.rom_data[8*i +: 8] = (a < 17'd256) ? a[7:0] : 8'h00;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.jmp = 1'b0;
        bus.jmp_addr = '0;
        bus.out_take = '0;
        step();
        step();
        check("rst_count", 32'(bus.out_count), 0);
        check("rst_pc", 32'(bus.out_pc), 0);
        check("rst_addr", 32'(bus.rom_addr), 0);
        check("rst_bytes", 32'(bus.out_bytes), 0);

        rst = 1'b0;
        step();
        check("fill1_count", 32'(bus.out_count), 2);
        check("fill1_bytes", 32'(bus.out_bytes), 32'h0100);
        check("fill1_pc", 32'(bus.out_pc), 0);
        step();
        check("fill2_count", 32'(bus.out_count), 4);
        check("fill2_addr", 32'(bus.rom_addr), 4);
        step();
        check("full_addr", 32'(bus.rom_addr), 4);
        check("full_count", 32'(bus.out_count), 4);

        bus.out_take = 2'd2;
        for (int k = 0; k < 4; k++) begin
            check("drain2_pc", 32'(bus.out_pc), 32'(2 * k));
            check("drain2_bytes", 32'(bus.out_bytes), 32'(((2 * k + 1) << 8) | (2 * k)));
            check("drain2_count", 32'(bus.out_count), (k == 0) ? 4 : 2);
            step();
        end

        bus.out_take = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        bus.out_take = 2'd1;
        for (int k = 0; k < 4; k++) begin
            check("drain1_pc", 32'(bus.out_pc), 32'(k));
            check("drain1_bytes", 32'(bus.out_bytes), 32'(((k + 1) << 8) | k));
            check("drain1_count", 32'(bus.out_count), (k == 0) ? 4 : (k == 1) ? 3 : (k == 2) ? 2 : 3);
            step();
        end

        bus.out_take = '0;
        bus.jmp = 1'b1;
        bus.jmp_addr = 16'h00FE;
        step();
        bus.jmp = 1'b0;
        check("jmp_count0", 32'(bus.out_count), 0);
        check("jmp_addr", 32'(bus.rom_addr), 32'h00FE);
        check("jmp_bytes0", 32'(bus.out_bytes), 0);
        step();
        check("jmp_count", 32'(bus.out_count), 2);
        check("jmp_pc", 32'(bus.out_pc), 32'h00FE);
        check("jmp_bytes", 32'(bus.out_bytes), 32'hFFFE);
        bus.out_take = 2'd2;
        step();
        bus.out_take = '0;
        check("romend_bytes", 32'(bus.out_bytes), 0);
        check("romend_pc", 32'(bus.out_pc), 32'h0100);
        check("romend_count", 32'(bus.out_count), 2);

        bus.jmp = 1'b1;
        bus.jmp_addr = 16'h0040;
        step();
        bus.jmp = 1'b0;
        bus.out_take = 2'd2;
        step();
        check("over0_pc", 32'(bus.out_pc), 32'h0040);
        check("over0_count", 32'(bus.out_count), 2);
        bus.out_take = 2'd1;
        step();
        check("pop1_pc", 32'(bus.out_pc), 32'h0041);
        check("pop1_count", 32'(bus.out_count), 3);
        bus.out_take = 2'd2;
        step();
        check("pop2_pc", 32'(bus.out_pc), 32'h0043);
        check("pop2_count", 32'(bus.out_count), 1);
        step();
        check("over1_pc", 32'(bus.out_pc), 32'h0043);
        check("over1_count", 32'(bus.out_count), 3);
        check("over1_bytes", 32'(bus.out_bytes), 32'h4443);

        bus.jmp = 1'b1;
        bus.jmp_addr = 16'h0080;
        step();
        bus.jmp = 1'b0;
        bus.out_take = '0;
        check("jmptake_count", 32'(bus.out_count), 0);
        check("jmptake_pc", 32'(bus.out_pc), 32'h0080);
        step();
        check("jmptake_bytes", 32'(bus.out_bytes), 32'h8180);

        bus.jmp = 1'b1;
        bus.jmp_addr = 16'hFFFF;
        step();
        bus.jmp = 1'b0;
        step();
        check("wrap_pc0", 32'(bus.out_pc), 32'hFFFF);
        bus.out_take = 2'd1;
        step();
        check("wrap_pc1", 32'(bus.out_pc), 0);
        check("wrap_count", 32'(bus.out_count), 3);
        step();
        bus.out_take = '0;
        step();
        check("midrst_pre_count", 32'(bus.out_count), 4);
        check("midrst_pre_pc", 32'(bus.out_pc), 1);
        rst = 1'b1;
        step();
        check("midrst_count", 32'(bus.out_count), 0);
        check("midrst_pc", 32'(bus.out_pc), 0);
        check("midrst_addr", 32'(bus.rom_addr), 0);
        check("midrst_bytes", 32'(bus.out_bytes), 0);
        rst = 1'b0;
        step();
        check("refill_count", 32'(bus.out_count), 2);
        check("refill_bytes", 32'(bus.out_bytes), 32'h0100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
